// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl - HI/LO multiply/divide sequencer beside the EX stage.
//
// Runs MULT/MULTU as a 32-step shift-add and DIV/DIVU as a 32-step restoring
// divide on operand magnitudes, then applies the sign fix when HI/LO are
// committed. MTHI/MTLO write HI/LO with no stall. MFHI/MFLO read combinationally.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   -> MULT/MULTU use a single-cycle 64-bit multiply (MUL state skipped)
//   undefined -> 32-iteration shift-add multiply
//
// Ports:
//   clk       in   rising-edge clock
//   rst_p     in   synchronous active-high reset
//   flush     in   abandon any in-flight op (beats op_valid)
//   op_valid  in   EX holds a muldiv-class instruction
//   op[2:0]   in   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO
//   src1/src2 in   forwarded rs/rt operands
//   busy      out  stall EX
//   done      out  one-cycle pulse when a long op commits HI/LO
//   mf_data   out  HI for MFHI, LO for MFLO
//   hi/lo     out  architectural HI/LO
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, next_state;
  logic [4:0]  cnt;
  logic [63:0] acc;      // MUL: {partial product, remaining multiplier}; DIV: quotient in [31:0]
  logic [31:0] rem;      // DIV partial remainder (always < divisor between steps)
  logic [31:0] opb;      // multiplicand or divisor magnitude
  logic        neg_res;
  logic        neg_rem;
  logic        is_div;

  logic        sgn_op;
  logic        long_op;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;

  function automatic logic [31:0] mag(input logic signed [31:0] x, input logic sgn);
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
    mag = (sgn && x[31]) ? 32'(-x) : 32'(x);
  endfunction

  function automatic logic [63:0] fix64(input logic [63:0] v, input logic neg);
    fix64 = neg ? -v : v;
  endfunction

  function automatic logic [31:0] fix32(input logic [31:0] v, input logic neg);
    fix32 = neg ? -v : v;
  endfunction

  assign sgn_op  = ~op[0];
  assign long_op = ~op[2];
  assign mf_data = op[0] ? lo : hi;

  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign div_shift = {rem, acc[31]};
  assign div_diff  = div_shift - {1'b0, opb};

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && long_op) begin
            busy = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            next_state = op[1] ? DIV : DONE;
`else
            next_state = op[1] ? DIV : MUL;
`endif
          end
        end
        MUL, DIV: begin
          busy = 1'b1;
          if (cnt == 5'd31) next_state = DONE;
        end
        DONE: begin
          done       = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Control state and architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state <= IDLE;
      cnt   <= 5'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= next_state;
      if (!flush && (state == MUL || state == DIV)) cnt <= cnt + 5'd1;
      else                                          cnt <= 5'd0;
      if (!flush && state == IDLE && op_valid) begin
        if (op == 3'd4) hi <= src1;
        if (op == 3'd5) lo <= src1;
      end
      if (!flush && state == DONE) begin
        if (is_div) begin
          lo <= fix32(acc[31:0], neg_res);
          hi <= fix32(rem, neg_rem);
        end else begin
          {hi, lo} <= fix64(acc, neg_res);
        end
      end
    end
  end

  // Iterative datapath; only meaningful once an op has been accepted
  always_ff @(posedge clk) begin
    if (state == IDLE && op_valid && long_op) begin
      opb     <= mag(src2, sgn_op);
      neg_res <= sgn_op && (src1[31] ^ src2[31]);
      neg_rem <= sgn_op && src1[31];
      is_div  <= op[1];
      rem     <= 32'd0;
`ifdef MULDIV_FAST_MUL_EN
      acc <= op[1] ? {32'd0, mag(src1, sgn_op)}
                   : {32'd0, mag(src1, sgn_op)} * {32'd0, mag(src2, sgn_op)};
`else
      acc <= {32'd0, mag(src1, sgn_op)};
`endif
    end else if (state == MUL) begin
      acc <= {mul_sum, acc[31:1]};
    end else if (state == DIV) begin
      // Restoring step: keep the difference only when it did not go negative
      if (!div_diff[32]) begin
        rem <= div_diff[31:0];
        acc <= {acc[63:32], acc[30:0], 1'b1};
      end else begin
        rem <= div_shift[31:0];
        acc <= {acc[63:32], acc[30:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst_p;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int ncmp = 0;
  int nerr = 0;

  muldiv_ctrl dut (
    .clk      (clk),
    .rst_p    (rst_p),
    .flush    (flush),
    .op_valid (op_valid),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .busy     (busy),
    .done     (done),
    .mf_data  (mf_data),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a long op in the current (IDLE) cycle, run it to completion, then
  // check committed HI/LO directly and through MFHI/MFLO.
  task automatic long_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int cyc;
    int nb;
    int lat;
`ifdef MULDIV_FAST_MUL_EN
    lat = o[1] ? 33 : 1;
`else
    lat = 33;
`endif
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    #1;
    cyc = 0; nb = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      tick;
      cyc++;
    end
    chk({tag, " done_cycle"}, 32'(cyc), 32'(lat));
    chk({tag, " busy_cycles"}, 32'(nb), 32'(lat));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    tick;
    op_valid = 1'b0;
    #1;
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    op_valid = 1'b1; op = 3'd6;
    #1;
    chk({tag, " mfhi"}, mf_data, ehi);
    chk({tag, " mf_busy"}, 32'(busy), 32'd0);
    op = 3'd7;
    #1;
    chk({tag, " mflo"}, mf_data, elo);
    op_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    rst_p = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0;
    tick;
    tick;
    rst_p = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);

    long_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    long_op(3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
    long_op(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min");
    long_op(3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7");
    long_op(3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    long_op(3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_zero");

    // MTHI then MFHI: zero stall; MF in same cycle as MT sees the old value
    tick;
    op_valid = 1'b1; op = 3'd4; src1 = 32'hDEADBEEF;
    #1;
    chk("mthi busy", 32'(busy), 32'd0);
    tick;
    op = 3'd6;
    #1;
    chk("mfhi data", mf_data, 32'hDEADBEEF);
    chk("mfhi busy", 32'(busy), 32'd0);
    op = 3'd5; src1 = 32'hCAFEF00D;
    #1;
    chk("mtlo busy", 32'(busy), 32'd0);
    tick;
    op = 3'd7;
    #1;
    chk("mflo data", mf_data, 32'hCAFEF00D);
    op_valid = 1'b0;

    long_op(3'd0, 32'd2, 32'd3, 32'd0, 32'd6, "mult_2_3");

    // Flush mid-DIVU: no commit, no done
    tick;
    op_valid = 1'b1; op = 3'd4; src1 = 32'h12345678;
    tick;
    op = 3'd5;
    tick;
    op = 3'd3; src1 = 32'd1000; src2 = 32'd3;
    #1;
    chk("flush busy c0", 32'(busy), 32'd1);
    repeat (10) tick;
    chk("flush busy c10 pre", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush busy c10", 32'(busy), 32'd0);
    chk("flush done c10", 32'(done), 32'd0);
    tick;
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("flush idle c11", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      tick;
    end
    chk("flush no done", 32'(pulses), 32'd0);
    chk("flush hi", hi, 32'h12345678);
    chk("flush lo", lo, 32'h12345678);

    // Reset mid-DIV, then a clean MULTU
    op_valid = 1'b1; op = 3'd2; src1 = 32'hFFFFFFF9; src2 = 32'd2;
    #1;
    repeat (15) tick;
    chk("rstmid busy c15", 32'(busy), 32'd1);
    rst_p = 1'b1;
    tick;
    rst_p = 1'b0; op_valid = 1'b0;
    #1;
    chk("rstmid hi", hi, 32'd0);
    chk("rstmid lo", lo, 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid done", 32'(done), 32'd0);
    long_op(3'd1, 32'd4, 32'd4, 32'd0, 32'd16, "multu_4_4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the HI/LO multiply/divide resource of the 5-stage MIPS pipeline. Sits beside the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX, runs iterative shift-add multiply and restoring divide, and owns the HI/LO registers. Raises `busy` to hold EX while an operation is in flight. Cancels in-flight work on pipeline flush.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_p`  in  1  reset, synchronous, active-high.
- `flush`  in  1  exception/cancel. Abandons any in-flight op. Priority over `op_valid`.
- `op_valid`  in  1  EX holds a valid muldiv-class instruction.
- `op`  in  3  encoding: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `src1`, `src2`  in  32 each  rs/rt operands (already forwarded).
- `busy`  out  1  EX must not advance.
- `done`  out  1  one-cycle pulse in the cycle HI/LO are committed by a long op.
- `mf_data`  out  32  combinational HI (MFHI) or LO (MFLO).
- `hi`, `lo`  out  32 each  architectural HI/LO registers.

## Operation
- States:
  - IDLE
  - MUL: 32 iterations, counter 0..31
  - DIV: 32 iterations, counter 0..31
  - DONE
- IDLE, `op_valid && !flush`:
  - MULT/MULTU → MUL. DIV/DIVU → DIV.
  - On entry, latch operand magnitudes: absolute value for signed ops, raw value for unsigned. Latch result signs. Clear counter.
  - MTHI/MTLO: write `src1` to HI/LO at the end of the cycle. Stay IDLE.
  - MFHI/MFLO: read only. Stay IDLE.
- MUL: one shift-add step per cycle on the 32-bit magnitudes into a 64-bit product. After counter 31 → DONE.
- DIV: one restoring step per cycle. 33-bit partial remainder. Quotient bit shifted in each cycle. After counter 31 → DONE.
- DONE:
  - Write HI/LO: product = {HI,LO}; quotient → LO, remainder → HI.
  - Apply sign fix: negate the product/quotient if the source signs differ; the remainder takes the dividend's sign.
  - Assert `done`, then → IDLE.
  - Never accepts a new op. `op_valid` is still high in this cycle for the same instruction, which leaves EX now.
- Magnitude of 0x80000000 is handled as unsigned 0x80000000.
- Divide by zero: no trap, no hang, full latency.
  - DIVU gives LO=0xFFFFFFFF, HI=`src1`.
  - DIV gives the magnitude result with the sign fix applied.
- `busy` = `!flush && ((state==IDLE && op_valid && op∈{0..3}) || state∈{MUL,DIV})`. MF/MT never raise `busy`.
- `flush` in any state: next state IDLE, counter cleared, no HI/LO write, no `done`.
- `rst_p`, including mid-operation: state IDLE, HI=LO=0, counter 0, `busy`=0, `done`=0.

## Timing
- Long op accepted in cycle 0 (IDLE):
  - `busy`=1 in cycles 0–32.
  - MUL/DIV in cycles 1–32.
  - DONE in cycle 33: `busy`=0, `done`=1.
  - HI/LO hold new values from cycle 34.
- MTHI/MTLO: zero stall. `hi`/`lo` update the cycle after acceptance.
- MFHI/MFLO in cycle 34 or later read the committed result.
- `mf_data` has no bypass: an MF in the same cycle as MTHI/MTLO reads the old value. The pipeline already serialises these.
- Flush asserted in cycle k of a long op: `busy`=0 in cycle k, IDLE in cycle k+1.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational 64-bit multiply; the MUL state is bypassed.
  - Accept in cycle 0 (`busy`=1), DONE in cycle 1 (`done`=1, `busy`=0), HI/LO valid from cycle 2.
  - DIV is unchanged.
- Undefined: 32-iteration shift-add multiply as described above.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` high 33 cycles, `done` at cycle 33, HI=0xFFFFFFFE, LO=0x00000001. With `MULDIV_FAST_MUL_EN`, `done` at cycle 1.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIVU 100/7 → LO=14, HI=2. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5/0 → LO=0xFFFFFFFF, HI=5, `done` at cycle 33.
- DIVU issued with HI=LO=0x12345678, `flush` at cycle 10 → `busy`=0 at cycle 10, IDLE at 11, `done` never pulses, HI/LO stay 0x12345678.
- MTHI 0xDEADBEEF, then MFHI next cycle → `busy` never high, `mf_data`=0xDEADBEEF. MULT 2×3 followed by MFLO → MFLO held by pipeline until cycle 34, reads 6.
- `rst_p` asserted at cycle 15 of a DIV → next cycle HI=LO=0, `busy`=0. A new MULTU 4×4 then completes normally with LO=16.
